// File: rtl/data_mem_stage_if.sv
// Bus between the EX stage, the data_mem_stage block and MEM/WB.
//   Upstream request : valid_i, mem_read_i, mem_write_i, reg_write_i,
//                      addr_i (effective address or pass-through value),
//                      wdata_i (store data), rd_i (destination register)
//   Upstream control : stall_o (combinational hold of all upstream stages)
//   Writeback        : wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o
//   Exception        : misalign_o (one-cycle pulse for a dropped access)
// The modport named slave belongs to the stage; master belongs to whoever
// drives the requests (pipeline or testbench).
interface data_mem_stage_if;
  logic        valid_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        reg_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;

  logic        stall_o;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic        misalign_o;

  modport master (
    output valid_i, mem_read_i, mem_write_i, reg_write_i, addr_i, wdata_i, rd_i,
    input  stall_o, wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o, misalign_o
  );

  modport slave (
    input  valid_i, mem_read_i, mem_write_i, reg_write_i, addr_i, wdata_i, rd_i,
    output stall_o, wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o, misalign_o
  );
endinterface

// File: rtl/data_mem_stage.sv
// data_mem_stage: MEM stage of the pipelined MIPS core.
// Word loads/stores against an internal DEPTH_WORDS x 32 data memory with a
// fixed WAIT_CYCLES latency; non-memory instructions pass addr_i through to
// writeback after one cycle. While an access is in flight stall_o holds the
// upstream stages; it drops in the final access cycle so upstream advances on
// the same edge that the access completes.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous, active-high reset
//   bus    : data_mem_stage_if.slave (request, stall, writeback, misalign)
// Parameters:
//   DEPTH_WORDS : memory depth in words (power of two)
//   WAIT_CYCLES : access latency in cycles, 1..15
// Build option:
//   MEM_MISALIGN_TRAP_EN : when defined, a memory op with addr_i[1:0] != 0 is
//   dropped and flagged on misalign_o; otherwise addresses are word-truncated
//   and misalign_o is tied low.
// States:
//   IDLE | accepting a new instruction
//   BUSY | memory access in flight, cnt_q counts remaining cycles
module data_mem_stage #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk_i,
  input logic             rst_i,
  data_mem_stage_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [4:0]    rd_q, rd_d;
  logic          reg_write_q, reg_write_d;
  logic          store_q, store_d;

  logic          wb_valid_q, wb_valid_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_reg_write_q, wb_reg_write_d;

  logic          mem_op;
  logic          drop_req;
  logic          mem_we;

  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the index wrap away; the low two bits only matter when
  // the misalign trap is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

  assign mem_op = bus.valid_i && (bus.mem_read_i || bus.mem_write_i);

`ifdef MEM_MISALIGN_TRAP_EN
  assign drop_req = (state_q == IDLE) && mem_op && (bus.addr_i[1:0] != 2'b00);
`else
  assign drop_req = 1'b0;
`endif

  // Stall covers the accepting cycle plus every BUSY cycle except the last.
  assign bus.stall_o = (state_q == IDLE) ? (mem_op && !drop_req)
                                         : (cnt_q != 4'd1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    store_d        = store_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = 32'd0;
    wb_rd_d        = 5'd0;
    wb_reg_write_d = 1'b0;
    mem_we         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (!mem_op) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = bus.addr_i;
            wb_rd_d        = bus.rd_i;
            wb_reg_write_d = bus.reg_write_i;
          end else if (!drop_req) begin
            idx_d       = bus.addr_i[AW+1:2];
            wdata_d     = bus.wdata_i;
            rd_d        = bus.rd_i;
            reg_write_d = bus.reg_write_i;
            // read+write together behaves as a store
            store_d     = bus.mem_write_i;
            cnt_d       = 4'(WAIT_CYCLES);
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (store_q) begin
            mem_we = 1'b1;
          end else begin
            wb_data_d      = mem[idx_q];
            wb_reg_write_d = reg_write_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign bus.misalign_o = misalign_q;
`else
  assign bus.misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      idx_q          <= '0;
      wdata_q        <= 32'd0;
      rd_q           <= 5'd0;
      reg_write_q    <= 1'b0;
      store_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      store_q        <= store_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q     <= drop_req;
`endif
    end
  end

  // Memory is deliberately not reset. A reset during BUSY forces IDLE
  // asynchronously, so a pending store never reaches this write port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.wb_rd_o        = wb_rd_q;
  assign bus.wb_reg_write_o = wb_reg_write_q;

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

  localparam int DEPTH = 128;
  localparam int W     = 2;
  localparam int AW    = 7;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] model_mem [DEPTH];

  data_mem_stage_if bus ();

  data_mem_stage #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.valid_i     = 1'($urandom_range(0, 1));
    bus.mem_read_i  = 1'($urandom_range(0, 1));
    bus.mem_write_i = 1'($urandom_range(0, 1));
    bus.reg_write_i = 1'($urandom_range(0, 1));
    bus.addr_i      = $urandom;
    bus.wdata_i     = $urandom;
    bus.rd_i        = 5'($urandom_range(0, 31));
  endtask

  // Presents one instruction at posedge+1 with the stage idle, walks it to
  // completion and checks stall profile and writeback against the model.
  // Returns at posedge+1 of the cycle in which the result is visible.
  task automatic do_op(input string tag, input logic v, input logic rdm, input logic wrm,
                       input logic rw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    logic        memop;
    logic        drop;
    logic        acc;
    int          n;
    int          idx;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mis;

    memop = v && (rdm || wrm);
    drop  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    drop  = memop && (a[1:0] != 2'b00);
`endif
    acc   = memop && !drop;
    n     = acc ? W + 1 : 1;
    idx   = int'(a[AW+1:2]);

    e_valid = v && !drop;
    e_mis   = drop;
    e_rd    = rd;
    e_data  = 32'd0;
    e_rw    = 1'b0;
    if (v && !memop) begin
      e_data = a;
      e_rw   = rw;
    end else if (acc && wrm) begin
      model_mem[idx] = wd;
    end else if (acc) begin
      e_data = model_mem[idx];
      e_rw   = rw;
    end

    bus.valid_i     = v;
    bus.mem_read_i  = rdm;
    bus.mem_write_i = wrm;
    bus.reg_write_i = rw;
    bus.addr_i      = a;
    bus.wdata_i     = wd;
    bus.rd_i        = rd;

    for (int c = 0; c < n; c++) begin
      @(negedge clk_i);
      chk({tag, ".stall"}, 32'(bus.stall_o), 32'(acc && (c < W)));
      if (c > 0) chk({tag, ".busy_wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      if (c < n - 1) scramble_inputs();
    end
    bus.valid_i = 1'b0;

    chk({tag, ".wb_valid"}, 32'(bus.wb_valid_o), 32'(e_valid));
    chk({tag, ".misalign"}, 32'(bus.misalign_o), 32'(e_mis));
    if (e_valid || e_mis) chk({tag, ".wb_reg_write"}, 32'(bus.wb_reg_write_o), 32'(e_rw));
    if (e_valid) begin
      chk({tag, ".wb_data"}, bus.wb_data_o, e_data);
      chk({tag, ".wb_rd"}, 32'(bus.wb_rd_o), 32'(e_rd));
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        v, rdm, wrm, rw;
    int          kind;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = $urandom;
      dut.mem[i]   = model_mem[i];
    end
    bus.valid_i     = 1'b0;
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b0;
    bus.reg_write_i = 1'b0;
    bus.addr_i      = 32'd0;
    bus.wdata_i     = 32'd0;
    bus.rd_i        = 5'd0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset.stall", 32'(bus.stall_o), 32'd0);
    chk("reset.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("reset.wb_data", bus.wb_data_o, 32'd0);
    chk("reset.wb_rd", 32'(bus.wb_rd_o), 32'd0);
    chk("reset.wb_reg_write", 32'(bus.wb_reg_write_o), 32'd0);
    chk("reset.misalign", 32'(bus.misalign_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    do_op("passthru", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h0, 5'd5);
    do_op("store10", 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd2);
    do_op("load10", 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd8);
    do_op("store200", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h1234, 5'd1);
    do_op("load000", 1'b1, 1'b1, 1'b0, 1'b1, 32'h000, 32'h0, 5'd4);
    do_op("load13", 1'b1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd3);
    do_op("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    do_op("load10b", 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd6);

    // Reset during the second BUSY cycle of a store must discard it.
    do_op("store20", 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'hAAAA_0001, 5'd0);
    bus.valid_i     = 1'b1;
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b1;
    bus.addr_i      = 32'h20;
    bus.wdata_i     = 32'hFFFF_FFFF;
    bus.rd_i        = 5'd7;
    @(posedge clk_i);
    #1;
    bus.valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_busy.stall", 32'(bus.stall_o), 32'd0);
    chk("rst_busy.wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_busy.wb_data", bus.wb_data_o, 32'd0);
    chk("rst_busy.wb_rd", 32'(bus.wb_rd_o), 32'd0);
    chk("rst_busy.wb_reg_write", 32'(bus.wb_reg_write_o), 32'd0);
    chk("rst_busy.misalign", 32'(bus.misalign_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    do_op("load20", 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd10);

    do_op("rdwr30", 1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h55, 5'd9);
    do_op("load30", 1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 5'd11);

    for (int k = 0; k < 80; k++) begin
      v    = ($urandom_range(0, 7) != 0);
      kind = int'($urandom_range(0, 3));
      rdm  = (kind == 1) || (kind == 3);
      wrm  = (kind == 2) || (kind == 3);
      rw   = 1'($urandom_range(0, 1));
      a    = $urandom;
      if (kind != 0) begin
        a[AW+1:2] = 7'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      end
      do_op("rand", v, rdm, wrm, rw, a, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
